// File: rtl/mc_datapath.sv
// Multicycle ARM-subset datapath: PC/IR/Data/A/B/ALUOut, 15-entry register file,
// immediate extension, 4-function ALU with NZCV flags and result/address muxing.
module mc_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ReadData,
    input  logic        PCWrite,
    input  logic        RegWrite,
    input  logic        IRWrite,
    input  logic        AdrSrc,
    input  logic [1:0]  RegSrc,
    input  logic        ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  ResultSrc,
    input  logic [1:0]  ImmSrc,
    input  logic [1:0]  ALUControl,
    output logic [31:0] Adr,
    output logic [31:0] WriteData,
    output logic [31:0] Instr,
    output logic [3:0]  ALUFlags
);

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned NREG = 15;
    localparam logic [AW-1:0] PC_ADDR = AW'(15);

    // architectural and inter-step registers
    logic [DW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] data;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic [DW-1:0] aluout;
    logic [DW-1:0] rf [NREG];

    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] ext_imm;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic [DW-1:0] b_op;
    logic          cin;
    logic [DW:0]   sum;
    logic [DW-1:0] alu_result;
    logic          flag_n;
    logic          flag_z;
    logic          flag_c;
    logic          flag_v;
    logic          arith;
    logic [DW-1:0] result;

    assign Instr     = ir;
    assign WriteData = b_reg;

    // register-file addressing
    always_comb begin
        ra1 = RegSrc[0] ? PC_ADDR : ir[19:16];
        ra2 = RegSrc[1] ? ir[15:12] : ir[3:0];
        wa  = ir[15:12];
    end

    // address 15 reads the live Result instead of a stored register
    always_comb begin
        rd1 = (ra1 == PC_ADDR) ? result : rf[ra1];
        rd2 = (ra2 == PC_ADDR) ? result : rf[ra2];
    end

    // immediate extension
    always_comb begin
        ext_imm = '0;
        case (ImmSrc)
            2'b00:   ext_imm = DW'(ir[7:0]);
            2'b01:   ext_imm = DW'(ir[11:0]);
            2'b10:   ext_imm = {{6{ir[23]}}, ir[23:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

    // ALU operand selection
    always_comb begin
        src_a = ALUSrcA ? pc : a_reg;
        src_b = '0;
        case (ALUSrcB)
            2'b00:   src_b = b_reg;
            2'b01:   src_b = ext_imm;
            2'b10:   src_b = DW'(4);
            default: src_b = '0;
        endcase
    end

    // subtraction reuses the adder as a + ~b + 1
    always_comb begin
        cin   = (ALUControl == 2'b01);
        b_op  = cin ? ~src_b : src_b;
        sum   = {1'b0, src_a} + {1'b0, b_op} + (DW+1)'(cin);
        arith = ~ALUControl[1];
        alu_result = '0;
        case (ALUControl)
            2'b00, 2'b01: alu_result = sum[DW-1:0];
            2'b10:        alu_result = src_a & src_b;
            default:      alu_result = src_a | src_b;
        endcase
    end

    // flags: overflow when both adder inputs agree in sign and the sum differs
    always_comb begin
        flag_n   = alu_result[DW-1];
        flag_z   = (alu_result == '0);
        flag_c   = arith & sum[DW];
        flag_v   = arith & (src_a[DW-1] == b_op[DW-1]) & (sum[DW-1] != src_a[DW-1]);
        ALUFlags = {flag_n, flag_z, flag_c, flag_v};
    end

    // result and memory address selection
    always_comb begin
        result = '0;
        case (ResultSrc)
            2'b00:   result = aluout;
            2'b01:   result = data;
            2'b10:   result = alu_result;
            default: result = '0;
        endcase
        Adr = AdrSrc ? result : pc;
    end

    // state update; reset wins over every enable
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            ir     <= '0;
            data   <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            aluout <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (PCWrite) begin
                pc <= result;
            end
            if (IRWrite) begin
                ir <= ReadData;
            end
            data   <= ReadData;
            a_reg  <= rd1;
            b_reg  <= rd2;
            aluout <= alu_result;
            if (RegWrite && (wa != PC_ADDR)) begin
                rf[wa] <= result;
            end
        end
    end

endmodule
